// File: rtl/dpll_backtrack_ctrl_if.sv
// Decision/backtrack request bus plus formula-stack controls for the DPLL sequencer.
interface dpll_backtrack_ctrl_if #(
    parameter int unsigned VAR_W  = 3,
    parameter int unsigned LVL_W  = 4,
    parameter int unsigned FORM_W = 16
);
    // requester side
    logic              dec_req;
    logic [VAR_W-1:0]  dec_var;
    logic              dec_pol;
    logic [FORM_W-1:0] cur_formula;
    logic              conf_req;
    logic              dec_ack;
    logic              bt_valid;
    logic [FORM_W-1:0] bt_formula;
    logic [VAR_W-1:0]  bt_var;
    logic              bt_pol;
    logic              unsat;
    logic              ovf;
    logic              err;
    logic              busy;
    logic [LVL_W-1:0]  level;
    // formula stack side
    logic              stk_push;
    logic              stk_pop;
    logic [FORM_W-1:0] stk_din;
    logic [FORM_W-1:0] stk_top;
    logic              stk_full;
    logic              stk_empty;

    // The sequencer serves requests and drives the stack controls.
    modport slave (
        input  dec_req, dec_var, dec_pol, cur_formula, conf_req,
        input  stk_top, stk_full, stk_empty,
        output dec_ack, bt_valid, bt_formula, bt_var, bt_pol, unsat, ovf, err, busy, level,
        output stk_push, stk_pop, stk_din
    );

    // Requester plus formula stack.
    modport master (
        output dec_req, dec_var, dec_pol, cur_formula, conf_req,
        output stk_top, stk_full, stk_empty,
        input  dec_ack, bt_valid, bt_formula, bt_var, bt_pol, unsat, ovf, err, busy, level,
        input  stk_push, stk_pop, stk_din
    );
endinterface

// File: rtl/dpll_backtrack_ctrl.sv
// DPLL decision/backtrack sequencer: records per-level decisions, pushes the pre-decision
// formula, and on conflict unwinds flipped levels to retry the deepest unflipped one.
module dpll_backtrack_ctrl #(
    parameter int unsigned DEPTH  = 10,
    parameter int unsigned VAR_W  = 3,
    parameter int unsigned LVL_W  = 4,
    parameter int unsigned FORM_W = 16
) (
    input logic                  clock,
    input logic                  reset,
    dpll_backtrack_ctrl_if.slave bus
);
    localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(DEPTH);

    typedef enum logic [2:0] {
        st_idle,
        st_push,
        st_bt_check,
        st_bt_done,
        st_unsat
    } state_t;

    state_t            state_q;
    logic [LVL_W-1:0]  level_q;
    logic [DEPTH-1:0]  flipped_q;
    logic [DEPTH-1:0]  pol_mem_q;
    logic [VAR_W-1:0]  var_mem_q [DEPTH];
    logic [VAR_W-1:0]  lat_var_q;
    logic              lat_pol_q;
    logic [FORM_W-1:0] stk_din_q;
    logic [FORM_W-1:0] bt_formula_q;
    logic [VAR_W-1:0]  bt_var_q;
    logic              bt_pol_q;
    logic              dec_ack_q;
    logic              bt_valid_q;
    logic              ovf_q;
    logic              stk_push_q;
    logic              unsat_q;
    logic              err_q;
    logic [LVL_W-1:0]  top_idx;
    logic              pop_now;

    assign top_idx = level_q - LVL_W'(1);

    // Pop is combinational so the stack's new top is visible the cycle after the pop,
    // in time for the next BT_CHECK evaluation.
    always_comb begin
        pop_now = 1'b0;
        if (state_q == st_bt_check && level_q != '0 && !bus.stk_empty) begin
            pop_now = flipped_q[top_idx];
        end
    end

    // Sequencer FSM with registered handshake outputs and decision record.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= st_idle;
            level_q      <= '0;
            flipped_q    <= '0;
            pol_mem_q    <= '0;
            lat_var_q    <= '0;
            lat_pol_q    <= 1'b0;
            stk_din_q    <= '0;
            bt_formula_q <= '0;
            bt_var_q     <= '0;
            bt_pol_q     <= 1'b0;
            dec_ack_q    <= 1'b0;
            bt_valid_q   <= 1'b0;
            ovf_q        <= 1'b0;
            stk_push_q   <= 1'b0;
            unsat_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            dec_ack_q  <= 1'b0;
            bt_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            stk_push_q <= 1'b0;
            unique case (state_q)
                st_idle: begin
                    // Conflict wins; a simultaneous decision is dropped silently.
                    if (bus.conf_req) begin
                        state_q <= st_bt_check;
                    end else if (bus.dec_req) begin
                        if (bus.stk_full || level_q == MAX_LVL) begin
                            ovf_q <= 1'b1;
                        end else begin
                            lat_var_q  <= bus.dec_var;
                            lat_pol_q  <= bus.dec_pol;
                            stk_din_q  <= bus.cur_formula;
                            stk_push_q <= 1'b1;
                            dec_ack_q  <= 1'b1;
                            state_q    <= st_push;
                        end
                    end
                end
                st_push: begin
                    var_mem_q[level_q] <= lat_var_q;
                    pol_mem_q[level_q] <= lat_pol_q;
                    flipped_q[level_q] <= 1'b0;
                    level_q            <= level_q + LVL_W'(1);
                    state_q            <= st_idle;
                end
                st_bt_check: begin
                    if (level_q == '0) begin
                        unsat_q <= 1'b1;
                        state_q <= st_unsat;
                    end else if (bus.stk_empty) begin
                        err_q   <= 1'b1;
                        unsat_q <= 1'b1;
                        state_q <= st_unsat;
                    end else if (pop_now) begin
                        flipped_q[top_idx] <= 1'b0;
                        level_q            <= top_idx;
                    end else begin
                        // Retry this level with the opposite polarity; its stack entry stays.
                        bt_formula_q       <= bus.stk_top;
                        bt_var_q           <= var_mem_q[top_idx];
                        bt_pol_q           <= ~pol_mem_q[top_idx];
                        pol_mem_q[top_idx] <= ~pol_mem_q[top_idx];
                        flipped_q[top_idx] <= 1'b1;
                        bt_valid_q         <= 1'b1;
                        state_q            <= st_bt_done;
                    end
                end
                st_bt_done: state_q <= st_idle;
                st_unsat:   state_q <= st_unsat;
                default:    state_q <= st_idle;
            endcase
        end
    end

    assign bus.dec_ack    = dec_ack_q;
    assign bus.bt_valid   = bt_valid_q;
    assign bus.bt_formula = bt_formula_q;
    assign bus.bt_var     = bt_var_q;
    assign bus.bt_pol     = bt_pol_q;
    assign bus.unsat      = unsat_q;
    assign bus.ovf        = ovf_q;
    assign bus.err        = err_q;
    assign bus.busy       = (state_q != st_idle);
    assign bus.level      = level_q;
    assign bus.stk_push   = stk_push_q;
    assign bus.stk_pop    = pop_now;
    assign bus.stk_din    = stk_din_q;
endmodule

// File: tb/tb_dpll_backtrack_ctrl.sv
// Scoreboard bench for dpll_backtrack_ctrl: a record-stack reference model queues expected
// responses; a negedge monitor pops and compares whenever the DUT responds.
module tb_dpll_backtrack_ctrl;
    localparam int DEPTH  = 10;
    localparam int VAR_W  = 3;
    localparam int LVL_W  = 4;
    localparam int FORM_W = 16;
    localparam int K_ACK = 0, K_BT = 1, K_OVF = 2, K_UNSAT = 3;

    typedef struct {
        int                kind;
        int                cyc;
        logic [FORM_W-1:0] f;
        logic [VAR_W-1:0]  v;
        logic              p;
        int                pops;
        logic              err;
        int                lvl;
    } exp_t;

    typedef struct {
        logic [VAR_W-1:0]  v;
        logic              p;
        logic              fl;
        logic [FORM_W-1:0] f;
    } rec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t expq[$];
    rec_t m_stk[$];
    bit   m_unsat    = 1'b0;
    bit   lie_empty  = 1'b0;
    int   push_total = 0;

    dpll_backtrack_ctrl_if #(.VAR_W(VAR_W), .LVL_W(LVL_W), .FORM_W(FORM_W)) bus ();

    dpll_backtrack_ctrl #(
        .DEPTH (DEPTH),
        .VAR_W (VAR_W),
        .LVL_W (LVL_W),
        .FORM_W(FORM_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Formula stack model sharing the controller reset.
    logic [FORM_W-1:0] stk_mem [DEPTH];
    int stk_cnt = 0;
    always @(posedge clock) begin
        if (reset) begin
            stk_cnt <= 0;
        end else if (bus.stk_push && stk_cnt < DEPTH) begin
            stk_mem[stk_cnt] <= bus.stk_din;
            stk_cnt          <= stk_cnt + 1;
        end else if (bus.stk_pop && stk_cnt > 0) begin
            stk_cnt <= stk_cnt - 1;
        end
    end
    assign bus.stk_top   = (stk_cnt > 0) ? stk_mem[stk_cnt-1] : '0;
    assign bus.stk_full  = (stk_cnt == DEPTH);
    assign bus.stk_empty = (stk_cnt == 0) || lie_empty;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: count stack activity and check each response against the queue head.
    initial begin
        int   push_cnt;
        int   pop_cnt;
        bit   unsat_seen;
        int   act_kind;
        exp_t e;
        push_cnt   = 0;
        pop_cnt    = 0;
        unsat_seen = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                push_cnt   = 0;
                pop_cnt    = 0;
                unsat_seen = 1'b0;
            end else begin
                if (bus.stk_push) begin
                    push_cnt++;
                    push_total++;
                end
                if (bus.stk_pop) pop_cnt++;
                if (bus.stk_push || bus.stk_pop)
                    chk("push_pop_exclusive", 64'(bus.stk_push & bus.stk_pop), 0);
                if (unsat_seen) chk("unsat_sticky", 64'(bus.unsat), 1);
                if (bus.dec_ack || bus.bt_valid || bus.ovf || (bus.unsat && !unsat_seen)) begin
                    act_kind = bus.dec_ack ? K_ACK : bus.bt_valid ? K_BT : bus.ovf ? K_OVF : K_UNSAT;
                    if (expq.size() == 0) begin
                        chk("unexpected_response", 64'(act_kind), 64'hFFFF);
                    end else begin
                        e = expq.pop_front();
                        chk("resp_kind", 64'(act_kind), 64'(e.kind));
                        chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                        chk("resp_level", 64'(bus.level), 64'(e.lvl));
                        case (e.kind)
                            K_ACK: begin
                                chk("ack_stk_din", 64'(bus.stk_din), 64'(e.f));
                                chk("ack_push_count", 64'(push_cnt), 1);
                                chk("ack_pop_count", 64'(pop_cnt), 0);
                            end
                            K_BT: begin
                                chk("bt_formula", 64'(bus.bt_formula), 64'(e.f));
                                chk("bt_var", 64'(bus.bt_var), 64'(e.v));
                                chk("bt_pol", 64'(bus.bt_pol), 64'(e.p));
                                chk("bt_pop_count", 64'(pop_cnt), 64'(e.pops));
                                chk("bt_push_count", 64'(push_cnt), 0);
                            end
                            K_OVF: chk("ovf_push_count", 64'(push_cnt), 0);
                            default: begin
                                chk("unsat_pop_count", 64'(pop_cnt), 64'(e.pops));
                                chk("unsat_err", 64'(bus.err), 64'(e.err));
                                chk("unsat_busy", 64'(bus.busy), 1);
                            end
                        endcase
                    end
                    push_cnt = 0;
                    pop_cnt  = 0;
                    if (bus.unsat) unsat_seen = 1'b1;
                end
            end
        end
    end

    // Drive changes 2ns after the falling edge, after the monitor has sampled.
    task automatic tick();
        @(negedge clock);
        #2;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk("response_timeout", 64'(expq.size()), 0);
        expq.delete();
        tick();
        chk("level_after_op", 64'(bus.level), 64'(m_stk.size()));
        chk("busy_after_op", 64'(bus.busy), 64'(m_unsat));
        chk("unsat_after_op", 64'(bus.unsat), 64'(m_unsat));
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.dec_req    = 1'b0;
        bus.conf_req   = 1'b0;
        lie_empty      = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        expq.delete();
        m_stk.delete();
        m_unsat = 1'b0;
        chk("rst_level", 64'(bus.level), 0);
        chk("rst_unsat", 64'(bus.unsat), 0);
        chk("rst_err", 64'(bus.err), 0);
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_dec_ack", 64'(bus.dec_ack), 0);
        chk("rst_bt_valid", 64'(bus.bt_valid), 0);
        chk("rst_ovf", 64'(bus.ovf), 0);
        chk("rst_stk_push", 64'(bus.stk_push), 0);
        chk("rst_stk_pop", 64'(bus.stk_pop), 0);
        chk("rst_bt_formula", 64'(bus.bt_formula), 0);
        chk("rst_bt_var", 64'(bus.bt_var), 0);
        chk("rst_bt_pol", 64'(bus.bt_pol), 0);
        chk("rst_stk_din", 64'(bus.stk_din), 0);
    endtask

    task automatic decide(input logic [VAR_W-1:0] v, input logic p, input logic [FORM_W-1:0] f);
        exp_t e;
        rec_t r;
        e = '{kind: K_ACK, cyc: cyc + 1, f: f, v: '0, p: 1'b0, pops: 0, err: 1'b0,
              lvl: m_stk.size()};
        if (!m_unsat) begin
            if (m_stk.size() >= DEPTH) begin
                e.kind = K_OVF;
            end else begin
                r = '{v: v, p: p, fl: 1'b0, f: f};
                m_stk.push_back(r);
            end
            expq.push_back(e);
        end
        bus.dec_req     = 1'b1;
        bus.dec_var     = v;
        bus.dec_pol     = p;
        bus.cur_formula = f;
        tick();
        bus.dec_req = 1'b0;
        wait_done();
    endtask

    task automatic conflict(input bit with_dec);
        exp_t e;
        rec_t r;
        int   k;
        k = 0;
        if (!m_unsat) begin
            e = '{kind: K_BT, cyc: 0, f: '0, v: '0, p: 1'b0, pops: 0, err: 1'b0, lvl: 0};
            if (lie_empty && m_stk.size() > 0) begin
                e.kind  = K_UNSAT;
                e.err   = 1'b1;
                m_unsat = 1'b1;
            end else begin
                // Discard levels whose both polarities were tried.
                while (m_stk.size() > 0 && m_stk[m_stk.size()-1].fl) begin
                    void'(m_stk.pop_back());
                    k++;
                end
                if (m_stk.size() == 0) begin
                    e.kind  = K_UNSAT;
                    m_unsat = 1'b1;
                end else begin
                    r    = m_stk[m_stk.size()-1];
                    r.p  = ~r.p;
                    r.fl = 1'b1;
                    m_stk[m_stk.size()-1] = r;
                    e.f = r.f;
                    e.v = r.v;
                    e.p = r.p;
                end
            end
            e.cyc  = cyc + 2 + k;
            e.pops = k;
            e.lvl  = m_stk.size();
            expq.push_back(e);
        end
        bus.conf_req = 1'b1;
        if (with_dec) begin
            bus.dec_req     = 1'b1;
            bus.dec_var     = VAR_W'($urandom_range(1, 7));
            bus.dec_pol     = 1'($urandom_range(0, 1));
            bus.cur_formula = FORM_W'($urandom);
        end
        tick();
        bus.conf_req = 1'b0;
        bus.dec_req  = 1'b0;
        wait_done();
    endtask

    initial begin
        int pt;
        int r;
        bus.dec_req     = 1'b0;
        bus.dec_var     = '0;
        bus.dec_pol     = 1'b0;
        bus.cur_formula = '0;
        bus.conf_req    = 1'b0;
        tick();
        do_reset();

        // Conflict at level 0 right after reset.
        conflict(1'b0);
        do_reset();

        // Two decisions, then three conflicts down to UNSAT.
        decide(3'd1, 1'b1, 16'hA1F1);
        decide(3'd2, 1'b0, 16'hB2F2);
        conflict(1'b0);
        conflict(1'b0);
        conflict(1'b0);
        pt = push_total;
        decide(3'd3, 1'b1, 16'h3333);
        conflict(1'b0);
        repeat (4) tick();
        chk("no_push_in_unsat", 64'(push_total), 64'(pt));
        chk("unsat_still_set", 64'(bus.unsat), 1);

        // Fill all levels, then overflow.
        do_reset();
        for (int i = 0; i < DEPTH; i++) decide(VAR_W'(i % 7 + 1), 1'(i % 2), FORM_W'(16'h1000 + i));
        decide(3'd5, 1'b1, 16'hDEAD);
        decide(3'd6, 1'b0, 16'hBEEF);

        // Simultaneous decision and conflict at level 3.
        do_reset();
        decide(3'd1, 1'b0, 16'h0101);
        decide(3'd2, 1'b1, 16'h0202);
        decide(3'd3, 1'b0, 16'h0303);
        conflict(1'b1);

        // Stack reports empty while level > 0.
        do_reset();
        decide(3'd4, 1'b1, 16'h0404);
        decide(3'd5, 1'b0, 16'h0505);
        lie_empty = 1'b1;
        conflict(1'b0);
        chk("err_sticky", 64'(bus.err), 1);

        // Reset asserted while in BT_CHECK at level 4.
        do_reset();
        for (int i = 0; i < 4; i++) decide(VAR_W'(i + 1), 1'b1, FORM_W'(16'h2000 + i));
        bus.conf_req = 1'b1;
        tick();
        bus.conf_req = 1'b0;
        chk("busy_in_bt_check", 64'(bus.busy), 1);
        reset = 1'b1;
        expq.delete();
        m_stk.delete();
        tick();
        reset = 1'b0;
        chk("midrst_level", 64'(bus.level), 0);
        chk("midrst_unsat", 64'(bus.unsat), 0);
        chk("midrst_err", 64'(bus.err), 0);
        chk("midrst_stk_pop", 64'(bus.stk_pop), 0);
        chk("midrst_busy", 64'(bus.busy), 0);
        tick();

        // Randomised mix of decisions and conflicts.
        for (int i = 0; i < 160; i++) begin
            if (m_unsat) do_reset();
            r = $urandom_range(0, 99);
            if (r < 62)      decide(VAR_W'($urandom_range(1, 7)), 1'($urandom_range(0, 1)),
                                    FORM_W'($urandom));
            else if (r < 92) conflict(1'b0);
            else             conflict(1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #400000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1);
    end
endmodule

// File: doc/dpll_backtrack_ctrl.md
Name: dpll_backtrack_ctrl

Overview:
Decision/backtrack sequencer for the DPLL core. It owns the push/pop controls of the formula stack and keeps a per-level decision record (variable, polarity, flipped flag). On a new decision it pushes the pre-decision formula. On a conflict it unwinds exhausted levels and returns the restored formula plus the flipped literal, or declares UNSAT.

Parameters:
DEPTH, 10, maximum decision levels; equals the formula stack depth.
VAR_W, 3, variable index width, matching the literal variable field in common.
LVL_W, 4, level counter width; must satisfy 2**LVL_W > DEPTH.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
dec_req  in  1  decision request; sampled only in IDLE
dec_var  in  VAR_W  decision variable; must be nonzero
dec_pol  in  1  decision polarity; 1 = positive literal
cur_formula  in  formula  formula before the decision is applied
conf_req  in  1  conflict detected; sampled only in IDLE
dec_ack  out  1  one-cycle pulse: decision recorded and pushed
bt_valid  out  1  one-cycle pulse: bt_formula and bt_var/bt_pol valid
bt_formula  out  formula  restored formula for the retried level
bt_var  out  VAR_W  variable to re-apply
bt_pol  out  1  flipped polarity
unsat  out  1  sticky; set when a conflict occurs with no unflipped level left
ovf  out  1  one-cycle pulse: decision rejected because the stack or level limit was reached
err  out  1  sticky; level>0 while stk_empty=1, indicating a stack/level mismatch
busy  out  1  state != IDLE
level  out  LVL_W  current decision depth
stk_push  out  1  formula stack write enable
stk_pop  out  1  formula stack pop
stk_din  out  formula  formula stack write data
stk_top  in  formula  current top-of-stack entry (front)
stk_full  in  1  formula stack full
stk_empty  in  1  formula stack empty

Behaviour:
- Reset: state IDLE, level=0, all flipped flags=0.
  - All 1-bit outputs are 0; unsat and err are cleared.
  - bt_formula, stk_din = zero_formula; bt_var=0, bt_pol=0.
- Stack contract:
  - stk_push / stk_pop take effect at the next rising edge.
  - stk_top reflects the new top in the following cycle.
  - Push and pop are never asserted in the same cycle.
- States: IDLE, PUSH, BT_CHECK, BT_DONE, UNSAT.
- IDLE:
  - conf_req=1 -> BT_CHECK. conf_req has priority; a simultaneous dec_req is dropped with no dec_ack and no ovf.
  - dec_req=1 and (stk_full=1 or level==DEPTH) -> ovf pulses next cycle; stay IDLE; nothing is recorded.
  - dec_req=1 otherwise -> latch cur_formula, dec_var, dec_pol; go to PUSH.
- PUSH (one cycle):
  - stk_push=1, stk_din=latched formula, dec_ack=1.
  - Record var/pol at index level with flipped=0; level++ at end of cycle.
  - -> IDLE.
  - Latency: dec_req at cycle N gives dec_ack/stk_push at N+1; level updated from N+2.
- BT_CHECK:
  - level==0 -> UNSAT.
  - level>0 and stk_empty -> set err, go to UNSAT.
  - flipped[level-1]=1 -> stk_pop=1, clear flipped[level-1], level--, stay in BT_CHECK. One popped level per cycle.
  - flipped[level-1]=0 -> capture bt_formula=stk_top, bt_var=var[level-1], bt_pol=~pol[level-1].
    - Set flipped[level-1]=1 and store the inverted pol.
    - The stack entry is NOT popped.
    - -> BT_DONE.
- BT_DONE: bt_valid=1 for one cycle -> IDLE. bt_* outputs hold until the next capture.
- Backtrack latency: conf_req at N with k flipped levels on top gives bt_valid at N+2+k.
- UNSAT:
  - unsat=1 from the cycle after entry.
  - busy=1; all requests ignored; no stack activity.
  - Exit only via reset.
- Requests outside IDLE are ignored, not queued. Requesters hold requests until they see dec_ack, bt_valid, unsat or ovf.
- Reset asserted mid-operation: the next edge returns to IDLE with all state cleared; pending pops/pushes are abandoned. The formula stack shares reset, so it is empty afterwards.
- level never exceeds DEPTH and never wraps below 0.

Test Plan:
- Reset, then dec_req var=1 pol=1 with formula F1 -> dec_ack and stk_push with stk_din=F1 exactly 1 cycle later; level=1; stk_push pulses once.
- Push F1 (v1,+), then F2 (v2,-); conf_req -> bt_valid 2 cycles after conf_req, bt_formula=F2, bt_var=2, bt_pol=1, level stays 2, no stk_pop.
- Continue: conf_req again -> one stk_pop pulse, level=1, bt_valid 3 cycles after conf_req, bt_formula=F1, bt_var=1, bt_pol=0.
- Continue: conf_req again -> stk_pop once, level=0, unsat=1 from the next cycle and sticky; subsequent dec_req gets no dec_ack and no stk_push.
- Push 10 decisions (stk_full=1, level=10); 11th dec_req -> ovf pulse, no dec_ack, level stays 10. Simultaneous dec_req+conf_req at level 3 -> backtrack only, no push.
- conf_req at level 0 immediately after reset -> unsat next-next cycle. Assert reset while in BT_CHECK with level 4 -> next cycle IDLE, level=0, unsat=0, err=0, stk_pop=0.
